keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 189 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// Row-scanning keypad controller: synchronises column sense, classifies each frame,
// debounces single-key presses and hands codes to a consumer with ack/overrun signalling.
module keypad_scanner #(
    parameter  int ROWS     = 4,
    parameter  int COLS     = 3,
    parameter  int SETTLE   = 4,
    parameter  int DEBOUNCE = 3,
    localparam int CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ROWS-1:0]   row,
    input  logic [COLS-1:0]   col,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    input  logic              key_ack,
    output logic              multi_key,
    output logic              overrun
);
    localparam int RIDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int SET_W  = $clog2(SETTLE);
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, CAND, PRESSED} state_t;

    logic [COLS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
    logic [RIDX_W-1:0] ridx_q, ridx_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [1:0]        acc_n_q, acc_n_d;
    logic [CODE_W-1:0] acc_idx_q, acc_idx_d;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic              key_valid_q, key_valid_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              multi_key_q, multi_key_d;
    logic              overrun_q, overrun_d;

    logic              sample, frame_end, emit;
    logic [1:0]        row_n, tot_n;
    logic [2:0]        sum_n;
    logic [CODE_W-1:0] row_idx, tot_idx;
    logic              res_none, res_one, res_multi;

    // Scan timing and per-frame accumulation; closed-switch count saturates at 2 (MULTI).
    always_comb begin
        sync1_d   = col;
        sync2_d   = sync1_q;
        sample    = (settle_q == SET_W'(SETTLE - 1));
        frame_end = sample && (ridx_q == RIDX_W'(ROWS - 1));
        settle_d  = sample ? '0 : settle_q + 1'b1;
        ridx_d    = ridx_q;
        if (sample) ridx_d = frame_end ? '0 : ridx_q + 1'b1;

        row_n   = 2'd0;
        row_idx = '0;
        for (int c = 0; c < COLS; c++) begin
            if (sync2_q[c]) begin
                if (row_n != 2'd2) row_n = row_n + 2'd1;
                row_idx = CODE_W'(int'(ridx_q) * COLS + c);
            end
        end
        sum_n   = {1'b0, acc_n_q} + {1'b0, row_n};
        tot_n   = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        tot_idx = (row_n != 2'd0) ? row_idx : acc_idx_q;

        acc_n_d   = acc_n_q;
        acc_idx_d = acc_idx_q;
        if (sample) begin
            acc_n_d   = frame_end ? 2'd0 : tot_n;
            acc_idx_d = frame_end ? '0 : tot_idx;
        end
        res_none  = frame_end && (tot_n == 2'd0);
        res_one   = frame_end && (tot_n == 2'd1);
        res_multi = frame_end && (tot_n == 2'd2);
    end

    always_comb begin
        row = '0;
        for (int r = 0; r < ROWS; r++) row[r] = (ridx_q == RIDX_W'(r));
    end

    // Debounce FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        emit    = 1'b0;
        case (state_q)
            IDLE: if (res_one) begin
                cand_d = tot_idx;
                if (DEBOUNCE == 1) begin
                    emit    = 1'b1;
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    state_d = CAND;
                    cnt_d   = CNT_W'(1);
                end
            end
            CAND: if (res_one) begin
                if (tot_idx == cand_q) begin
                    if (cnt_q + 1'b1 == CNT_W'(DEBOUNCE)) begin
                        emit    = 1'b1;
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cand_d = tot_idx;
                    cnt_d  = CNT_W'(1);
                end
            end else if (res_none || res_multi) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            PRESSED: if (res_none) begin
                if (cnt_q + 1'b1 == CNT_W'(DEBOUNCE)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (res_one || res_multi) begin
                cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Consumer handshake: an emit coinciding with ack replaces the code without a gap.
    always_comb begin
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        overrun_d   = overrun_q;
        multi_key_d = frame_end ? res_multi : multi_key_q;
        if (emit) begin
            if (!key_valid_q || key_ack) begin
                key_valid_d = 1'b1;
                key_code_d  = tot_idx;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (key_valid_q && key_ack) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            ridx_q      <= '0;
            settle_q    <= '0;
            acc_n_q     <= '0;
            acc_idx_q   <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            multi_key_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            ridx_q      <= ridx_d;
            settle_q    <= settle_d;
            acc_n_q     <= acc_n_d;
            acc_idx_q   <= acc_idx_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            multi_key_q <= multi_key_d;
            overrun_q   <= overrun_d;
        end
    end

    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign multi_key = multi_key_q;
    assign overrun   = overrun_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a frame-level run-length reference model checks every cycle,
// with directed press/bounce/overrun/reset scenarios, random traffic and a 1x1 instance.
module tb_keypad_scanner;
    localparam int R = 4, C = 3, S = 4, D = 3, FRAME = R * S, NK = R * C;

    logic          clk, reset, key_ack;
    logic [R-1:0]  row;
    logic [C-1:0]  col;
    logic          key_valid, multi_key, overrun;
    logic [3:0]    key_code;
    logic [NK-1:0] keys;

    logic          row2, col2, key2, kv2, code2, mk2, ov2, ack2;

    keypad_scanner #(.ROWS(R), .COLS(C), .SETTLE(S), .DEBOUNCE(D)) dut (
        .clk(clk), .reset(reset), .row(row), .col(col), .key_valid(key_valid),
        .key_code(key_code), .key_ack(key_ack), .multi_key(multi_key), .overrun(overrun));

    keypad_scanner #(.ROWS(1), .COLS(1), .SETTLE(4), .DEBOUNCE(1)) dut1 (
        .clk(clk), .reset(reset), .row(row2), .col(col2), .key_valid(kv2),
        .key_code(code2), .key_ack(ack2), .multi_key(mk2), .overrun(ov2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a closed switch shorts its row line onto its column line.
    always_comb begin
        col = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (row[r] && keys[r*C+c]) col[c] = 1'b1;
    end
    assign col2 = row2 & key2;

    int nchk = 0, nerr = 0;
    int cyc = 0, ack_mode = 0, pulses = 0, last_code = 0;
    bit m_kv, m_mk, m_ov, armed;
    int m_code, run_idx, run_len, none_len;
    logic prev_kv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a key is reported when, while armed, it has been the only closed switch
    // for D consecutive frames; re-arming needs D consecutive empty frames.
    task automatic model_edge();
        bit emit;
        int n, idx;
        emit = 0; idx = 0;
        if (reset) begin
            m_kv = 0; m_code = 0; m_mk = 0; m_ov = 0;
            armed = 1; run_len = 0; none_len = 0; run_idx = 0; cyc = 0;
            return;
        end
        if (cyc % FRAME == FRAME - 1) begin
            n = $countones(keys);
            for (int k = NK - 1; k >= 0; k--) if (keys[k]) idx = k;
            m_mk = (n >= 2);
            if (n == 1) begin
                if (run_len > 0 && run_idx == idx) run_len++;
                else begin run_idx = idx; run_len = 1; end
                none_len = 0;
                if (armed && run_len == D) begin emit = 1; armed = 0; end
            end else if (n == 0) begin
                run_len = 0; none_len++;
                if (none_len >= D) armed = 1;
            end else begin
                run_len = 0; none_len = 0;
            end
        end
        if (emit) begin
            if (!m_kv) begin m_kv = 1; m_code = idx; end
            else if (key_ack) m_code = idx;
            else m_ov = 1;
        end else if (m_kv && key_ack) m_kv = 0;
        cyc++;
    endtask

    task automatic tick();
        case (ack_mode)
            1:       key_ack = 1'b1;
            2:       key_ack = 1'($urandom_range(0, 1));
            3:       key_ack = m_kv;
            default: key_ack = 1'b0;
        endcase
        prev_kv = key_valid;
        @(posedge clk);
        model_edge();
        #1;
        chk("key_valid", 32'(key_valid), 32'(m_kv));
        chk("key_code", 32'(key_code), 32'(m_code));
        chk("multi_key", 32'(multi_key), 32'(m_mk));
        chk("overrun", 32'(overrun), 32'(m_ov));
        chk("row", 32'(row), 32'(1 << ((cyc % FRAME) / S)));
        if (key_valid && !prev_kv) begin pulses++; last_code = int'(key_code); end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n * FRAME; i++) tick();
    endtask

    task automatic set_key(input int k);
        keys = '0;
        if (k >= 0) keys[k] = 1'b1;
    endtask

    initial begin
        reset = 1'b1; key_ack = 1'b0; keys = '0; key2 = 1'b0; ack2 = 1'b0;
        tick(); tick();
        chk("reset_row", 32'(row), 32'd1);
        reset = 1'b0;

        // single key 5 held, consumer acks one cycle after valid
        ack_mode = 3; pulses = 0; set_key(5);
        frames(3);
        chk("k5_pulse", 32'(pulses), 32'd1);
        chk("k5_code", 32'(last_code), 32'd5);
        frames(3);
        chk("k5_no_repeat", 32'(pulses), 32'd1);
        set_key(-1); frames(4);

        // bouncing key 0
        pulses = 0; set_key(0); frames(2);
        set_key(-1); frames(1);
        set_key(0); frames(2);
        chk("bounce_quiet", 32'(pulses), 32'd0);
        frames(1);
        chk("bounce_pulse", 32'(pulses), 32'd1);
        chk("bounce_code", 32'(last_code), 32'd0);
        set_key(-1); frames(4);

        // two keys on row 2
        pulses = 0; keys = '0; keys[6] = 1'b1; keys[7] = 1'b1;
        frames(1);
        chk("multi_flag", 32'(multi_key), 32'd1);
        frames(4);
        chk("multi_no_emit", 32'(pulses), 32'd0);
        set_key(-1); frames(4);
        chk("multi_clear", 32'(multi_key), 32'd0);

        // overrun: key 4 unacked, then key 7
        ack_mode = 0; set_key(4); frames(4);
        set_key(-1); frames(4);
        set_key(7); frames(4);
        chk("ovr_valid", 32'(key_valid), 32'd1);
        chk("ovr_code", 32'(key_code), 32'd4);
        chk("ovr_flag", 32'(overrun), 32'd1);
        ack_mode = 1; tick(); ack_mode = 0;
        chk("ovr_ack_clear", 32'(key_valid), 32'd0);
        frames(1);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        set_key(-1); frames(4);

        // reset with key 9 two frames into debounce
        set_key(9); frames(2);
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_row", 32'(row), 32'd1);
        pulses = 0; frames(2);
        chk("rst_k9_wait", 32'(pulses), 32'd0);
        frames(1);
        chk("rst_k9_pulse", 32'(pulses), 32'd1);
        chk("rst_k9_code", 32'(last_code), 32'd9);

        // random traffic
        for (int f = 0; f < 50; f++) begin
            int sel;
            sel = int'($urandom_range(0, 7));
            if (sel == 3 || sel == 4) keys = '0;
            else if (sel == 5 || sel == 6) set_key(int'($urandom_range(0, NK - 1)));
            else if (sel == 7) begin
                set_key(int'($urandom_range(0, NK - 1)));
                keys[$urandom_range(0, NK - 1)] = 1'b1;
            end
            ack_mode = int'($urandom_range(0, 3));
            frames(1);
        end

        // 1x1 keypad, debounce of one frame
        ack_mode = 0; keys = '0;
        reset = 1'b1; tick(); reset = 1'b0;
        key2 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("k1_row", 32'(row2), 32'd1);
            chk("k1_valid", 32'(kv2), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("k1_code", 32'(code2), 32'd0);
        ack2 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("k1_held", 32'(kv2), 32'd0);
            chk("k1_row_hold", 32'(row2), 32'd1);
        end
        chk("k1_ovr", 32'(ov2), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
